// File: rtl/mul8_share_arb_pkg.sv
// Shared widths and payload types for the shared 8x8 signed multiplier arbiter.
package mul8_share_arb_pkg;

  localparam int unsigned MUL_W  = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic [MUL_W-1:0] a;
    logic [MUL_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/mul_signed8.sv
// Combinational two's-complement 8x8 -> 16 multiplier.
module mul_signed8
  import mul8_share_arb_pkg::*;
(
  input  logic [MUL_W-1:0]  a_i,
  input  logic [MUL_W-1:0]  b_i,
  output logic [PROD_W-1:0] z_c_o
);

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;

  // Sign-extend first so the full product survives in PROD_W bits.
  assign a_ext = PROD_W'($signed(a_i));
  assign b_ext = PROD_W'($signed(b_i));
  assign z_c_o = a_ext * b_ext;

endmodule

// File: rtl/rr_arb.sv
// Round-robin grant: first set request at or after the pointer, wrapping N-1 -> 0.
module rr_arb #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_c_o,
  output logic [IDW-1:0] id_c_o,
  output logic           any_c_o
);

  logic [IDW-1:0] idx_c;

  always_comb begin
    gnt_c_o = '0;
    id_c_o  = '0;
    any_c_o = 1'b0;
    idx_c   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_c = IDW'((32'(ptr_i) + k) % N);
      if (!any_c_o && req_i[idx_c]) begin
        any_c_o        = 1'b1;
        gnt_c_o[idx_c] = 1'b1;
        id_c_o         = idx_c;
      end
    end
  end

endmodule

// File: rtl/mul8_share_arb.sv
// N requesters share one signed multiplier through a two-stage operand/product pipeline.
module mul8_share_arb
  import mul8_share_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [N-1:0]         req_valid,
  input  logic [MUL_W*N-1:0]   req_a,
  input  logic [MUL_W*N-1:0]   req_b,
  output logic [N-1:0]         req_ready,
  output logic [N-1:0]         rsp_valid,
  output logic [PROD_W-1:0]    rsp_z,
  input  logic [N-1:0]         rsp_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  logic              v1_q, v1_d;
  logic [IDW-1:0]    id1_q, id1_d;
  op_pair_t          op1_q, op1_d;
  logic [N-1:0]      rsp_vld_q, rsp_vld_d;
  logic [PROD_W-1:0] z_q, z_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  logic [N-1:0]      gnt_c;
  logic [IDW-1:0]    gnt_id_c;
  logic              any_c;
  logic [PROD_W-1:0] z1_c;
  op_pair_t          sel_c;
  logic              drain_c, adv2_c, load1_c, accept_c;

  rr_arb #(.N(N), .IDW(IDW)) u_rr_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .gnt_c_o (gnt_c),
    .id_c_o  (gnt_id_c),
    .any_c_o (any_c)
  );

  mul_signed8 u_mul (
    .a_i   (op1_q.a),
    .b_i   (op1_q.b),
    .z_c_o (z1_c)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_c[i]) begin
        sel_c.a = req_a[MUL_W*i +: MUL_W];
        sel_c.b = req_b[MUL_W*i +: MUL_W];
      end
    end
  end

  assign drain_c  = |(rsp_vld_q & rsp_ready);
  assign adv2_c   = v1_q & (~(|rsp_vld_q) | drain_c);
  assign load1_c  = ~v1_q | adv2_c;
  // Held low while in reset so every output reads zero.
  assign req_ready = (clrn && load1_c) ? gnt_c : '0;
  assign accept_c  = clrn & load1_c & any_c;

  always_comb begin
    v1_d      = v1_q;
    id1_d     = id1_q;
    op1_d     = op1_q;
    rsp_vld_d = rsp_vld_q;
    z_d       = z_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;

    if (adv2_c) begin
      rsp_vld_d = N'(1) << id1_q;
      z_d       = z1_c;
    end else if (drain_c) begin
      rsp_vld_d = '0;
    end

    if (accept_c) begin
      v1_d  = 1'b1;
      id1_d = gnt_id_c;
      op1_d = sel_c;
      ptr_d = (gnt_id_c == IDW'(N-1)) ? '0 : gnt_id_c + IDW'(1);
    end else if (adv2_c) begin
      v1_d = 1'b0;
    end

    if (drain_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    busy_d = v1_d | (|rsp_vld_d);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v1_q      <= 1'b0;
      id1_q     <= '0;
      op1_q     <= '0;
      rsp_vld_q <= '0;
      z_q       <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      id1_q     <= id1_d;
      op1_q     <= op1_d;
      rsp_vld_q <= rsp_vld_d;
      z_q       <= z_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_z     = z_q;
  assign busy      = busy_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_mul8_share_arb.sv
// Directed and exhaustive-operand checks for mul8_share_arb with N=4.
module tb_mul8_share_arb;

  logic        clk = 1'b0;
  logic        clrn;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_z;
  logic [3:0]  rsp_ready;
  logic        busy;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul8_share_arb #(.N(4), .IDW(2)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_z     (rsp_z),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  task automatic do_reset();
    req_valid = 4'b0000;
    rsp_ready = 4'b1111;
    clrn      = 1'b0;
    tick();
    clrn      = 1'b1;
  endtask

  logic [15:0] t2_prod [4];
  logic [17:0] exp_q [$];
  logic [17:0] e;
  logic [15:0] idx;
  logic signed [7:0]  sa, sb;
  logic signed [15:0] pr;
  logic [1:0]  rid;
  int          nxt [4];
  int          accepted;
  int          cyc;
  logic        saw_ffff;

  initial begin
    t2_prod[0] = 16'hC080;
    t2_prod[1] = 16'h0001;
    t2_prod[2] = 16'hFFF1;
    t2_prod[3] = 16'h0064;

    // Reset state, with requests pending so gating of req_ready is visible.
    clrn      = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 4'b1111;
    repeat (2) tick();
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_z",     32'(rsp_z),     32'h0);
    check_eq("rst_op_count",  32'(op_count),  32'h0);
    check_eq("rst_busy",      32'(busy),      32'h0);
    check_eq("rst_req_ready", 32'(req_ready), 32'h0);

    // 1: -128 * -128 on requester 0
    clrn      = 1'b1;
    req_valid = 4'b0001;
    set_op(0, 8'h80, 8'h80);
    #1;
    check_eq("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    check_eq("t1_s1_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("t1_s1_busy",      32'(busy),      32'h1);
    tick();
    check_eq("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("t1_rsp_z",     32'(rsp_z),     32'h4000);
    tick();
    check_eq("t1_op_count",  32'(op_count),  32'h1);
    check_eq("t1_idle",      32'(rsp_valid), 32'h0);

    // 2: all requesters valid every cycle
    do_reset();
    set_op(0, 8'h7F, 8'h80);
    set_op(1, 8'hFF, 8'hFF);
    set_op(2, 8'h05, 8'hFD);
    set_op(3, 8'h0A, 8'h0A);
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      #1;
      check_eq("t2_grant", 32'(req_ready), 32'(4'(1) << (c % 4)));
      if (c >= 2) begin
        check_eq("t2_rsp_valid", 32'(rsp_valid), 32'(4'(1) << ((c - 2) % 4)));
        check_eq("t2_rsp_z",     32'(rsp_z),     32'(t2_prod[(c - 2) % 4]));
      end
      tick();
    end
    req_valid = 4'b0000;
    repeat (3) tick();
    check_eq("t2_op_count", 32'(op_count), 32'd10);

    // 3: stall on requester 2, S1 fills, then release
    do_reset();
    rsp_ready = 4'b1011;
    req_valid = 4'b0100;
    set_op(2, 8'h05, 8'hFD);
    #1;
    check_eq("t3_ready0", 32'(req_ready), 32'h4);
    tick();
    set_op(2, 8'h07, 8'h02);
    #1;
    check_eq("t3_ready1", 32'(req_ready), 32'h4);
    tick();
    set_op(2, 8'h01, 8'h01);
    #1;
    for (int c = 0; c < 5; c++) begin
      check_eq("t3_stall_valid", 32'(rsp_valid), 32'h4);
      check_eq("t3_stall_z",     32'(rsp_z),     32'hFFF1);
      check_eq("t3_stall_ready", 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 4'b1111;
    #1;
    check_eq("t3_release_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    #1;
    check_eq("t3_second_valid", 32'(rsp_valid), 32'h4);
    check_eq("t3_second_z",     32'(rsp_z),     32'h000E);
    check_eq("t3_cnt1",         32'(op_count),  32'd1);
    tick();
    check_eq("t3_third_z",      32'(rsp_z),     32'h0001);
    check_eq("t3_cnt2",         32'(op_count),  32'd2);
    tick();
    check_eq("t3_empty_valid",  32'(rsp_valid), 32'h0);
    check_eq("t3_empty_busy",   32'(busy),      32'h0);
    check_eq("t3_cnt3",         32'(op_count),  32'd3);
    check_eq("t3_z_hold",       32'(rsp_z),     32'h0001);

    // 4: pointer wrap after granting the last requester
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'h02, 8'h03);
    req_valid = 4'b1000;
    #1;
    check_eq("t4_grant3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b1010;
    #1;
    check_eq("t4_grant1", 32'(req_ready), 32'h2);
    tick();
    check_eq("t4_grant3b", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    repeat (3) tick();
    check_eq("t4_op_count", 32'(op_count), 32'd3);

    // 5: async reset with both stages full drops everything
    rsp_ready = 4'b0000;
    req_valid = 4'b0001;
    set_op(0, 8'h03, 8'h03);
    tick();
    tick();
    check_eq("t5_full_busy",  32'(busy),      32'h1);
    check_eq("t5_full_valid", 32'(rsp_valid), 32'h1);
    #2;
    clrn = 1'b0;
    #1;
    check_eq("t5_rst_valid", 32'(rsp_valid), 32'h0);
    check_eq("t5_rst_busy",  32'(busy),      32'h0);
    check_eq("t5_rst_cnt",   32'(op_count),  32'h0);
    check_eq("t5_rst_ready", 32'(req_ready), 32'h0);
    check_eq("t5_rst_z",     32'(rsp_z),     32'h0);
    tick();
    clrn      = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq("t5_no_rsp", 32'(rsp_valid), 32'h0);
    end
    check_eq("t5_cnt_after", 32'(op_count), 32'h0);

    // 6 + sweep: all 65536 operand pairs with random response stalls; count wraps to 0
    do_reset();
    for (int i = 0; i < 4; i++) nxt[i] = 0;
    accepted = 0;
    cyc      = 0;
    saw_ffff = 1'b0;
    while ((accepted < 65536 || exp_q.size() != 0) && cyc < 90000) begin
      for (int i = 0; i < 4; i++) begin
        if (nxt[i] < 16384) begin
          idx          = 16'(nxt[i] * 4 + i);
          req_valid[i] = 1'b1;
          set_op(i, idx[15:8], idx[7:0]);
        end else begin
          req_valid[i] = 1'b0;
        end
        rsp_ready[i] = ($urandom_range(31) != 0);
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          idx = 16'(nxt[i] * 4 + i);
          sa  = idx[15:8];
          sb  = idx[7:0];
          pr  = sa * sb;
          exp_q.push_back({2'(i), pr});
          nxt[i]++;
          accepted++;
        end
      end
      if (rsp_valid != 4'b0000) begin
        check_eq("sweep_onehot", 32'($onehot(rsp_valid)), 32'h1);
        rid = 2'd0;
        for (int j = 0; j < 4; j++) if (rsp_valid[j]) rid = 2'(j);
        if (rsp_ready[rid]) begin
          if (exp_q.size() == 0) begin
            check_eq("sweep_extra_rsp", 32'(rsp_valid), 32'h0);
          end else begin
            e = exp_q.pop_front();
            check_eq("sweep_rsp", 32'({rid, rsp_z}), 32'(e));
          end
        end
      end
      if (op_count == 16'hFFFF) saw_ffff = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("sweep_in_budget", 32'(cyc < 90000), 32'h1);
    check_eq("t6_saw_ffff",     32'(saw_ffff),    32'h1);
    check_eq("t6_wrap",         32'(op_count),    32'h0);
    check_eq("sweep_idle",      32'(busy),        32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
